// File: rtl/app_mem_pkg.sv
// Shared types and constants for the app_mem_responder memory-interface model.
package app_mem_pkg;

   localparam int APP_DATA_WIDTH = 128;
   localparam int APP_MASK_WIDTH = 16;
   localparam int APP_ADDR_WIDTH = 28;
   localparam int FIFO_DEPTH     = 4;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   typedef struct packed {
      logic [2:0]                cmd;
      logic [APP_ADDR_WIDTH-4:0] word;
   } cmd_entry_t;

   typedef struct packed {
      logic [APP_MASK_WIDTH-1:0] mask;
      logic [APP_DATA_WIDTH-1:0] data;
   } wdf_entry_t;

   // A set mask bit keeps the old byte.
   function automatic logic [APP_DATA_WIDTH-1:0] byte_merge(
      input logic [APP_DATA_WIDTH-1:0] old_w,
      input logic [APP_DATA_WIDTH-1:0] new_w,
      input logic [APP_MASK_WIDTH-1:0] mask
   );
      logic [APP_DATA_WIDTH-1:0] r;
      r = old_w;
      for (int b = 0; b < APP_MASK_WIDTH; b++)
         if (!mask[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
      return r;
   endfunction

endpackage

// File: rtl/app_resp_fifo.sv
// Small synchronous FIFO with registered full/empty; also exposes the next-cycle
// full flag so a registered ready can never admit a push into a full FIFO.
module app_resp_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         empty_o,
   output logic         full_nxt_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  store_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full_q, empty_q;
   logic          push_ok, pop_ok;

   assign pop_ok  = pop_i & ~empty_q;
   // Push into a full FIFO only succeeds alongside a pop; count then holds.
   assign push_ok = push_i & (~full_q | pop_ok);

   always_comb begin
      cnt_d = cnt_q;
      if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
      else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop_ok)  rptr_q <= rptr_q + 1'b1;
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == FULL_CNT);
         empty_q <= (cnt_d == '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) store_q[wptr_q] <= wdata_i;
   end

   assign rdata_o    = store_q[rptr_q];
   assign empty_o    = empty_q;
   assign full_nxt_o = (cnt_d == FULL_CNT);

endmodule

// File: rtl/app_mem_responder.sv
// Behavioural memory-controller responder: command/data FIFOs, fixed-latency reads.
// Optional refresh stalls on app_rdy when APP_MEM_RESPONDER_REFRESH_EN is defined.
module app_mem_responder
   import app_mem_pkg::*;
#(
   parameter int MEM_ADDR_BITS    = 6,
   parameter int RD_LATENCY       = 4,
   parameter int CALIB_CYCLES     = 64,
   parameter int REFRESH_INTERVAL = 256,
   parameter int REFRESH_CYCLES   = 8
) (
   input  logic                      uiclk,
   input  logic                      reset_n,
   input  logic [APP_ADDR_WIDTH-1:0] app_addr,
   input  logic [2:0]                app_cmd,
   input  logic                      app_en,
   output logic                      app_rdy,
   input  logic [APP_DATA_WIDTH-1:0] app_wdf_data,
   input  logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
   input  logic                      app_wdf_wren,
   input  logic                      app_wdf_end,
   output logic                      app_wdf_rdy,
   output logic [APP_DATA_WIDTH-1:0] app_rd_data,
   output logic                      app_rd_data_valid,
   output logic                      app_rd_data_end,
   output logic                      init_calib_complete,
   output logic                      err
);
   localparam int MEM_WORDS = 1 << MEM_ADDR_BITS;
   localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);

   logic [CAL_W-1:0] cal_cnt_q, cal_cnt_d;
   logic             calib_q, calib_d;
   logic             app_rdy_q, wdf_rdy_q, err_q, err_d;
   logic             ref_stall;

   cmd_entry_t cmd_in, cmd_hd;
   wdf_entry_t wdf_in, wdf_hd;
   logic       cmd_push, cmd_pop, cmd_empty, cmd_full_nxt;
   logic       dat_push, dat_pop, dat_empty, dat_full_nxt;
   logic       addr_bad, do_wr, do_rd, bad_cmd;

   logic [MEM_ADDR_BITS-1:0]  mem_idx;
   logic [APP_DATA_WIDTH-1:0] mem_q [MEM_WORDS];
   logic [APP_DATA_WIDTH-1:0] rd_word;

   logic [RD_LATENCY:0]                     vld_pipe;
   logic [RD_LATENCY:1]                     vld_pipe_q;
   logic [RD_LATENCY:0][APP_DATA_WIDTH-1:0] dat_pipe;
   logic [RD_LATENCY:1][APP_DATA_WIDTH-1:0] dat_pipe_q;

   // ---------------- calibration ----------------
   always_comb begin
      cal_cnt_d = cal_cnt_q;
      calib_d   = calib_q;
      if (!calib_q) begin
         cal_cnt_d = cal_cnt_q + 1'b1;
         if (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1)) calib_d = 1'b1;
      end
   end

`ifdef APP_MEM_RESPONDER_REFRESH_EN
   localparam int REF_W = $clog2(REFRESH_INTERVAL);
   logic [REF_W-1:0] ref_cnt_q;

   always_ff @(posedge uiclk or negedge reset_n) begin
      if (!reset_n)     ref_cnt_q <= '0;
      else if (calib_q) ref_cnt_q <= (ref_cnt_q == REF_W'(REFRESH_INTERVAL - 1)) ? '0 : ref_cnt_q + 1'b1;
   end

   // Last REFRESH_CYCLES slots of each interval block new commands.
   assign ref_stall = calib_q && (ref_cnt_q >= REF_W'(REFRESH_INTERVAL - REFRESH_CYCLES));
`else
   logic unused_ref;
   assign ref_stall  = 1'b0;
   assign unused_ref = (REFRESH_INTERVAL != 0) ^ (REFRESH_CYCLES != 0);
`endif

   // ---------------- accept side ----------------
   assign addr_bad = |app_addr[2:0];
   assign cmd_push = app_en & app_rdy_q & ~addr_bad;
   assign dat_push = app_wdf_wren & wdf_rdy_q;

   assign cmd_in.cmd  = app_cmd;
   assign cmd_in.word = app_addr[APP_ADDR_WIDTH-1:3];
   assign wdf_in.mask = app_wdf_mask;
   assign wdf_in.data = app_wdf_data;

   app_resp_fifo #(.W($bits(cmd_entry_t)), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
      .clk_i      (uiclk),
      .rst_ni     (reset_n),
      .push_i     (cmd_push),
      .wdata_i    (cmd_in),
      .pop_i      (cmd_pop),
      .rdata_o    (cmd_hd),
      .empty_o    (cmd_empty),
      .full_nxt_o (cmd_full_nxt)
   );

   app_resp_fifo #(.W($bits(wdf_entry_t)), .DEPTH(FIFO_DEPTH)) u_dat_fifo (
      .clk_i      (uiclk),
      .rst_ni     (reset_n),
      .push_i     (dat_push),
      .wdata_i    (wdf_in),
      .pop_i      (dat_pop),
      .rdata_o    (wdf_hd),
      .empty_o    (dat_empty),
      .full_nxt_o (dat_full_nxt)
   );

   // ---------------- pop / execute ----------------
   always_comb begin
      cmd_pop = 1'b0;
      dat_pop = 1'b0;
      do_wr   = 1'b0;
      do_rd   = 1'b0;
      bad_cmd = 1'b0;
      if (!cmd_empty) begin
         case (cmd_hd.cmd)
            CMD_READ: begin
               cmd_pop = 1'b1;
               do_rd   = 1'b1;
            end
            CMD_WRITE: begin
               // A write waits at the head until its data word exists.
               if (!dat_empty) begin
                  cmd_pop = 1'b1;
                  dat_pop = 1'b1;
                  do_wr   = 1'b1;
               end
            end
            default: begin
               cmd_pop = 1'b1;
               bad_cmd = 1'b1;
            end
         endcase
      end
   end

   assign mem_idx = cmd_hd.word[MEM_ADDR_BITS-1:0];
   assign rd_word = do_rd ? mem_q[mem_idx] : '0;

   // Storage has no reset so contents survive reset_n.
   always_ff @(posedge uiclk) begin
      if (do_wr) mem_q[mem_idx] <= byte_merge(mem_q[mem_idx], wdf_hd.data, wdf_hd.mask);
   end

   assign vld_pipe = {vld_pipe_q, do_rd};
   assign dat_pipe = {dat_pipe_q, rd_word};

   always_ff @(posedge uiclk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe_q <= '0;
         dat_pipe_q <= '0;
      end else begin
         vld_pipe_q <= vld_pipe[RD_LATENCY-1:0];
         dat_pipe_q <= dat_pipe[RD_LATENCY-1:0];
      end
   end

   // ---------------- status ----------------
   always_comb begin
      err_d = err_q
            | (app_en & app_rdy_q & addr_bad)
            | (dat_push & ~app_wdf_end)
            | bad_cmd
            | (~calib_q & (app_en | app_wdf_wren));
   end

   always_ff @(posedge uiclk or negedge reset_n) begin
      if (!reset_n) begin
         cal_cnt_q <= '0;
         calib_q   <= 1'b0;
         app_rdy_q <= 1'b0;
         wdf_rdy_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         cal_cnt_q <= cal_cnt_d;
         calib_q   <= calib_d;
         app_rdy_q <= calib_q & ~cmd_full_nxt & ~ref_stall;
         wdf_rdy_q <= calib_q & ~dat_full_nxt;
         err_q     <= err_d;
      end
   end

   logic unused_ok;
   assign unused_ok = ^cmd_hd.word[APP_ADDR_WIDTH-4:MEM_ADDR_BITS];

   assign app_rdy             = app_rdy_q;
   assign app_wdf_rdy         = wdf_rdy_q;
   assign init_calib_complete = calib_q;
   assign err                 = err_q;
   assign app_rd_data_valid   = vld_pipe[RD_LATENCY];
   assign app_rd_data_end     = vld_pipe[RD_LATENCY];
   assign app_rd_data         = dat_pipe[RD_LATENCY];

endmodule

// File: tb/tb_app_mem_responder.sv
// Scoreboard bench for app_mem_responder (default build, refresh disabled).
`timescale 1ns/1ps
module tb_app_mem_responder;
   import app_mem_pkg::*;

   localparam int RD_LAT = 4;
   localparam int CALIB  = 64;

   logic         uiclk = 1'b0;
   logic         reset_n = 1'b1;
   logic [27:0]  app_addr = '0;
   logic [2:0]   app_cmd = '0;
   logic         app_en = 1'b0;
   logic         app_rdy;
   logic [127:0] app_wdf_data = '0;
   logic [15:0]  app_wdf_mask = '0;
   logic         app_wdf_wren = 1'b0;
   logic         app_wdf_end = 1'b1;
   logic         app_wdf_rdy;
   logic [127:0] app_rd_data;
   logic         app_rd_data_valid;
   logic         app_rd_data_end;
   logic         init_calib_complete;
   logic         err;

   app_mem_responder #(.RD_LATENCY(RD_LAT), .CALIB_CYCLES(CALIB)) dut (
      .uiclk               (uiclk),
      .reset_n             (reset_n),
      .app_addr            (app_addr),
      .app_cmd             (app_cmd),
      .app_en              (app_en),
      .app_rdy             (app_rdy),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data         (app_rd_data),
      .app_rd_data_valid   (app_rd_data_valid),
      .app_rd_data_end     (app_rd_data_end),
      .init_calib_complete (init_calib_complete),
      .err                 (err)
   );

   always #5 uiclk = ~uiclk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int last_vld_cyc = 0;
   int n_rd = 0;
   logic [127:0] exp_q[$];
   logic [127:0] exp_w;
   logic [127:0] model [64];

   always @(posedge uiclk) cyc <= cyc + 1;

   // Read-return monitor: every valid beat must match the oldest expectation.
   always @(negedge uiclk) begin
      if (app_rd_data_valid === 1'b1) begin
         n_rd++;
         last_vld_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected got=%h expected no read data", app_rd_data);
         end else begin
            exp_w = exp_q.pop_front();
            if (app_rd_data !== exp_w || app_rd_data_end !== 1'b1) begin
               errors++;
               $display("FAIL rd_data got=%h end=%b expected=%h end=1", app_rd_data, app_rd_data_end, exp_w);
            end
         end
      end
   end

   task automatic tick();
      @(posedge uiclk);
      #1;
   endtask

   task automatic send_cmd(input logic [2:0] cmd, input logic [27:0] addr);
      int n = 0;
      app_cmd = cmd;
      app_addr = addr;
      app_en = 1'b1;
      while (app_rdy !== 1'b1 && n < 1000) begin tick(); n++; end
      if (app_rdy !== 1'b1) begin
         checks++; errors++;
         $display("FAIL cmd_accept_timeout app_rdy=%b expected=1", app_rdy);
      end
      tick();
      acc_cyc = cyc;
      app_en = 1'b0;
   endtask

   task automatic send_wdf(input logic [127:0] d, input logic [15:0] m, input logic last);
      int n = 0;
      app_wdf_data = d;
      app_wdf_mask = m;
      app_wdf_end = last;
      app_wdf_wren = 1'b1;
      while (app_wdf_rdy !== 1'b1 && n < 1000) begin tick(); n++; end
      if (app_wdf_rdy !== 1'b1) begin
         checks++; errors++;
         $display("FAIL wdf_accept_timeout app_wdf_rdy=%b expected=1", app_wdf_rdy);
      end
      tick();
      app_wdf_wren = 1'b0;
      app_wdf_end = 1'b1;
   endtask

   task automatic model_write(input logic [27:0] addr, input logic [127:0] d, input logic [15:0] m);
      int idx;
      idx = int'(addr[8:3]);
      for (int b = 0; b < 16; b++)
         if (!m[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
   endtask

   task automatic write_word(input logic [27:0] addr, input logic [127:0] d, input logic [15:0] m);
      send_wdf(d, m, 1'b1);
      send_cmd(CMD_WRITE, addr);
      model_write(addr, d, m);
   endtask

   task automatic read_word(input logic [27:0] addr);
      exp_q.push_back(model[int'(addr[8:3])]);
      send_cmd(CMD_READ, addr);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin tick(); n++; end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain pending=%0d expected=0", name, exp_q.size());
      end
      repeat (2) tick();
   endtask

   task automatic wait_calib();
      int n = 0;
      while (init_calib_complete !== 1'b1 && n < 300) begin tick(); n++; end
      checks++;
      if (init_calib_complete !== 1'b1) begin
         errors++;
         $display("FAIL calib_timeout init_calib_complete=%b expected=1", init_calib_complete);
      end
      tick();
   endtask

   task automatic do_reset();
      app_en = 1'b0;
      app_wdf_wren = 1'b0;
      reset_n = 1'b0;
      tick();
      exp_q.delete();
      tick();
      checks++;
      if (err !== 1'b0 || app_rd_data_valid !== 1'b0 || app_rdy !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs err=%b vld=%b rdy=%b expected=0", err, app_rd_data_valid, app_rdy);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      int n = 0;
      #2 reset_n = 1'b0;
      tick(); tick();
      checks++;
      if (app_rdy !== 1'b0 || app_wdf_rdy !== 1'b0) begin
         errors++; $display("FAIL reset_rdy rdy=%b wdf_rdy=%b expected=0", app_rdy, app_wdf_rdy);
      end
      checks++;
      if (app_rd_data_valid !== 1'b0 || app_rd_data_end !== 1'b0 || app_rd_data !== '0) begin
         errors++; $display("FAIL reset_rd vld=%b end=%b data=%h expected=0", app_rd_data_valid, app_rd_data_end, app_rd_data);
      end
      checks++;
      if (init_calib_complete !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL reset_status calib=%b err=%b expected=0", init_calib_complete, err);
      end
      reset_n = 1'b1;
      while (init_calib_complete !== 1'b1 && n < 300) begin tick(); n++; end
      checks++;
      if (n != CALIB) begin
         errors++; $display("FAIL calib_cycles got=%0d expected=%0d", n, CALIB);
      end
      checks++;
      if (app_rdy !== 1'b0) begin
         errors++; $display("FAIL rdy_early app_rdy=%b expected=0", app_rdy);
      end
      tick();
      checks++;
      if (app_rdy !== 1'b1 || app_wdf_rdy !== 1'b1) begin
         errors++; $display("FAIL rdy_after_calib rdy=%b wdf_rdy=%b expected=1", app_rdy, app_wdf_rdy);
      end
   endtask

   task automatic test_write_read();
      write_word(28'h008, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEA5, 16'h0000);
      read_word(28'h008);
      drain("write_read");
      checks++;
      if (last_vld_cyc - acc_cyc != RD_LAT) begin
         errors++; $display("FAIL rd_latency got=%0d expected=%0d", last_vld_cyc - acc_cyc, RD_LAT);
      end
   endtask

   task automatic test_data_delay();
      logic [127:0] d;
      int nrd0;
      d = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
      send_cmd(CMD_WRITE, 28'h018);
      model_write(28'h018, d, 16'h0000);
      for (int i = 0; i < 3; i++) read_word(28'h018);
      checks++;
      if (app_rdy !== 1'b0) begin
         errors++; $display("FAIL cmd_fifo_full app_rdy=%b expected=0", app_rdy);
      end
      nrd0 = n_rd;
      repeat (10) tick();
      checks++;
      if (n_rd != nrd0 || app_rdy !== 1'b0) begin
         errors++; $display("FAIL write_stall reads=%0d rdy=%b expected reads=%0d rdy=0", n_rd, app_rdy, nrd0);
      end
      send_wdf(d, 16'h0000, 1'b1);
      drain("data_delay");
      checks++;
      if (app_rdy !== 1'b1) begin
         errors++; $display("FAIL rdy_recover app_rdy=%b expected=1", app_rdy);
      end
   endtask

   task automatic test_mask();
      logic [127:0] d1, d2, d3, e;
      d1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      d2 = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_99C3;
      d3 = 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878;
      write_word(28'h020, d1, 16'h0000);
      write_word(28'h020, d2, 16'hFFFE);
      e = {d1[127:8], d2[7:0]};
      exp_q.push_back(e);
      send_cmd(CMD_READ, 28'h020);
      write_word(28'h020, d3, 16'h00FF);
      e = {d3[127:64], e[63:0]};
      exp_q.push_back(e);
      send_cmd(CMD_READ, 28'h020);
      drain("mask");
   endtask

   task automatic test_wrap();
      write_word(28'h208, 128'hCAFE_F00D_0000_0000_0000_0000_0000_0208, 16'h0000);
      read_word(28'h008);
      write_word(28'hFFFFFF8, 128'h7E7E_7E7E_0000_0000_0000_0000_0000_003F, 16'h0000);
      read_word(28'h1F8);
      drain("wrap");
   endtask

   task automatic test_back_to_back();
      int nrd0;
      for (int i = 0; i < 8; i++)
         write_word(28'(32'h100 + i * 8), {$urandom, $urandom, $urandom, $urandom}, 16'h0000);
      nrd0 = n_rd;
      for (int i = 0; i < 8; i++) read_word(28'(32'h100 + i * 8));
      drain("back_to_back");
      checks++;
      if (n_rd - nrd0 != 8) begin
         errors++; $display("FAIL b2b_count got=%0d expected=8", n_rd - nrd0);
      end
   endtask

   task automatic test_err();
      int nrd0;
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL err_clean err=%b expected=0", err);
      end
      nrd0 = n_rd;
      send_cmd(3'b010, 28'h008);
      repeat (RD_LAT + 3) tick();
      checks++;
      if (err !== 1'b1 || n_rd != nrd0) begin
         errors++; $display("FAIL err_bad_cmd err=%b reads=%0d expected err=1 reads=%0d", err, n_rd, nrd0);
      end
      // Reset with a read in flight: it must be dropped.
      exp_q.push_back(model[1]);
      send_cmd(CMD_READ, 28'h008);
      do_reset();
      wait_calib();
      nrd0 = n_rd;
      send_cmd(CMD_READ, 28'h009);
      repeat (RD_LAT + 3) tick();
      checks++;
      if (err !== 1'b1 || n_rd != nrd0) begin
         errors++; $display("FAIL err_misaligned err=%b reads=%0d expected err=1 reads=%0d", err, n_rd, nrd0);
      end
      do_reset();
      tick();
      app_en = 1'b1; app_cmd = CMD_READ; app_addr = 28'h0;
      tick();
      app_en = 1'b0;
      wait_calib();
      repeat (RD_LAT + 2) tick();
      checks++;
      if (err !== 1'b1 || n_rd != nrd0) begin
         errors++; $display("FAIL err_precalib err=%b reads=%0d expected err=1 reads=%0d", err, n_rd, nrd0);
      end
      do_reset();
      wait_calib();
      send_wdf(128'h1, 16'hFFFF, 1'b0);
      tick();
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL err_wdf_end err=%b expected=1", err);
      end
      do_reset();
      wait_calib();
      read_word(28'h008);
      read_word(28'h020);
      drain("retain");
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL err_after_reset err=%b expected=0", err);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_data_delay();
      test_mask();
      test_wrap();
      test_back_to_back();
      test_err();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

endmodule
